// File: rtl/conv1d_sram_banked_if.sv
// -----------------------------------------------------------------------------
// conv1d_sram_banked_if
// Multi-port request/grant/response bundle for the banked conv1d scratchpad.
// Every field is a per-port array indexed by requester number.
//
// Signals (per port p):
//   req[p]    requester -> memory   request valid
//   we[p]     requester -> memory   1 = write, 0 = read
//   addr[p]   requester -> memory   word address
//   wdata[p]  requester -> memory   write data
//   be[p]     requester -> memory   byte enables (writes only)
//   gnt[p]    memory -> requester   request accepted this cycle
//   rvalid[p] memory -> requester   response valid (one cycle after accept)
//   rdata[p]  memory -> requester   read data, zero otherwise
//
// Modports: master (requester side), slave (memory side).
// -----------------------------------------------------------------------------
interface conv1d_sram_banked_if #(
    parameter int NUM_WORDS  = 256,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2
);
    localparam int AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BeWidth   = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                  req;
    logic [NUM_PORTS-1:0]                  we;
    logic [NUM_PORTS-1:0][AddrWidth-1:0]   addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata;
    logic [NUM_PORTS-1:0][BeWidth-1:0]     be;
    logic [NUM_PORTS-1:0]                  gnt;
    logic [NUM_PORTS-1:0]                  rvalid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/conv1d_sram_banked.sv
// -----------------------------------------------------------------------------
// conv1d_sram_banked
// Multi-port, word-interleaved, multi-bank scratchpad for the conv1d
// accelerator. NUM_WORDS are split over NUM_BANKS banks (bank = low address
// bits, row = remaining bits). Each bank behaves like a 1-cycle-latency
// single-port SRAM with byte enables. NUM_PORTS requesters share the banks;
// each bank runs its own round-robin arbiter so requesters hitting different
// banks are all served in the same cycle.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   bus             conv1d_sram_banked_if.slave (req/we/addr/wdata/be in,
//                   gnt/rvalid/rdata out, one lane per requester)
//   conflict_cnt_o  [31:0] saturating count of (port, cycle) pairs that
//                   requested but were not granted; only present when
//                   CONV1D_SRAM_CONFLICT_CNT_EN is defined
//
// Optional feature macro: CONV1D_SRAM_CONFLICT_CNT_EN
// -----------------------------------------------------------------------------
module conv1d_sram_banked #(
    parameter int NUM_WORDS  = 256,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_PORTS  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    conv1d_sram_banked_if.slave      bus
`ifdef CONV1D_SRAM_CONFLICT_CNT_EN
    ,
    output logic [31:0]              conflict_cnt_o
`endif
);
    localparam int AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BankSelW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BeWidth   = DATA_WIDTH / 8;
    localparam int Depth     = NUM_WORDS / NUM_BANKS;
    localparam int RowW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int PortW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // ------------------------------------------------------------------
    // Address decode: bank select and in-bank row per requester
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0][BankSelW-1:0] port_bank;
    logic [NUM_PORTS-1:0][RowW-1:0]     port_row;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
            if (NUM_BANKS > 1) begin : g_multi
                assign port_bank[gi] = bus.addr[gi][BankSelW-1:0];
                assign port_row[gi]  = RowW'(bus.addr[gi] >> BankSelW);
            end else begin : g_single
                assign port_bank[gi] = '0;
                assign port_row[gi]  = RowW'(bus.addr[gi]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-bank round-robin arbitration
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0][PortW-1:0] rr_q, rr_d;
    logic [NUM_BANKS-1:0]            bank_act;
    logic [NUM_BANKS-1:0][PortW-1:0] bank_sel;

    always_comb begin
        int idx;
        idx      = 0;
        bank_act = '0;
        bank_sel = '0;
        rr_d     = rr_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            // Walk the ports starting at the bank's priority pointer; the
            // first one aiming at this bank wins.
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_q[b]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!bank_act[b] && bus.req[idx] &&
                    (port_bank[idx] == BankSelW'(b))) begin
                    bank_act[b] = 1'b1;
                    bank_sel[b] = PortW'(idx);
                end
            end
            if (bank_act[b]) begin
                rr_d[b] = (int'(bank_sel[b]) == NUM_PORTS - 1) ? '0
                                                               : bank_sel[b] + 1'b1;
            end
        end
    end

    logic [NUM_PORTS-1:0] gnt_c;

    always_comb begin
        gnt_c = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            gnt_c[p] = !rst_i && bus.req[p] &&
                       bank_act[port_bank[p]] &&
                       (bank_sel[port_bank[p]] == PortW'(p));
        end
    end

    assign bus.gnt = gnt_c;

    // ------------------------------------------------------------------
    // Banks: each is a single-port, byte-enabled array with registered read
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [Depth];
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  bank_req;
            logic                  bank_we;
            logic [RowW-1:0]       bank_row;
            logic [DATA_WIDTH-1:0] bank_wdata;
            logic [BeWidth-1:0]    bank_be;

            assign bank_req   = bank_act[gi] && !rst_i;
            assign bank_we    = bus.we[bank_sel[gi]];
            assign bank_row   = port_row[bank_sel[gi]];
            assign bank_wdata = bus.wdata[bank_sel[gi]];
            assign bank_be    = bus.be[bank_sel[gi]];

            always_ff @(posedge clk_i) begin
                if (bank_req) begin
                    if (bank_we) begin
                        for (int i = 0; i < BeWidth; i++) begin
                            if (bank_be[i]) begin
                                mem[bank_row][8*i +: 8] <= bank_wdata[8*i +: 8];
                            end
                        end
                    end else begin
                        rdata_q <= mem[bank_row];
                    end
                end
            end

            assign bank_rdata[gi] = rdata_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response tracking: remember which bank each accepted request went to
    // so the registered bank output can be routed back one cycle later.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0]               rvalid_q;
    logic [NUM_PORTS-1:0][BankSelW-1:0] bank_q;
    logic [NUM_PORTS-1:0]               we_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q     <= '0;
            rvalid_q <= '0;
            bank_q   <= '0;
            we_q     <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= gnt_c;
            bank_q   <= port_bank;
            we_q     <= bus.we;
        end
    end

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_c;

    always_comb begin
        rdata_c = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            // Write responses and idle cycles return zero data.
            if (rvalid_q[p] && !we_q[p]) begin
                rdata_c[p] = bank_rdata[bank_q[p]];
            end
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_c;

`ifdef CONV1D_SRAM_CONFLICT_CNT_EN
    // ------------------------------------------------------------------
    // Conflict counter: one increment per requesting-but-stalled port
    // ------------------------------------------------------------------
    logic [31:0] cnt_q, cnt_d;
    logic [32:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.req[p] && !gnt_c[p]) begin
                cnt_sum = cnt_sum + 33'd1;
            end
        end
        cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_conv1d_sram_banked.sv
// -----------------------------------------------------------------------------
// tb_conv1d_sram_banked
// Directed bench for conv1d_sram_banked (4 banks, 2 ports). A word-level
// memory model plus per-port expected-response slots are updated from the
// accepted requests; a negedge process compares every cycle. Directed
// literal expectations pin the grant order and key read values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv1d_sram_banked;
    localparam int NW = 256;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv1d_sram_banked_if #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

`ifdef CONV1D_SRAM_CONFLICT_CNT_EN
    logic [31:0] conflict_cnt;
    logic [31:0] cnt_before;
`endif

    conv1d_sram_banked #(
        .NUM_WORDS (NW),
        .DATA_WIDTH(DW),
        .NUM_BANKS (NB),
        .NUM_PORTS (NP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
`ifdef CONV1D_SRAM_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o(conflict_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: flat word memory + expected response per port
    // ------------------------------------------------------------------
    logic [31:0] mem_m   [NW];
    bit          known_m [NW];
    bit          exp_v   [NP];
    logic [31:0] exp_d   [NP];
    bit          exp_k   [NP];

    initial begin
        for (int a = 0; a < NW; a++) known_m[a] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            exp_v[p] = 1'b0;
            exp_d[p] = '0;
            exp_k[p] = 1'b0;
        end
    end

    always @(negedge clk) begin
        int nreq;
        int ngnt;
        int a;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("rst_gnt_p%0d", p), 32'(bus.gnt[p]), 32'd0);
                chk($sformatf("rst_rvalid_p%0d", p), 32'(bus.rvalid[p]), 32'd0);
                chk($sformatf("rst_rdata_p%0d", p), bus.rdata[p], 32'd0);
                exp_v[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("rvalid_p%0d", p), 32'(bus.rvalid[p]), 32'(exp_v[p]));
                if (!exp_v[p] || exp_k[p])
                    chk($sformatf("rdata_p%0d", p), bus.rdata[p], exp_v[p] ? exp_d[p] : 32'd0);
                chk($sformatf("gnt_wo_req_p%0d", p), 32'(bus.gnt[p] & ~bus.req[p]), 32'd0);
            end
            // Each bank that is asked serves exactly one port; idle banks none.
            for (int b = 0; b < NB; b++) begin
                nreq = 0;
                ngnt = 0;
                for (int p = 0; p < NP; p++) begin
                    if (bus.req[p] && (int'(bus.addr[p]) % NB == b)) nreq++;
                    if (bus.gnt[p] && (int'(bus.addr[p]) % NB == b)) ngnt++;
                end
                if (nreq > 0 || ngnt > 0)
                    chk($sformatf("bank%0d_grants", b), 32'(ngnt), (nreq > 0) ? 32'd1 : 32'd0);
            end
            // Next-cycle responses; reads see memory before this cycle's writes.
            for (int p = 0; p < NP; p++) begin
                a = int'(bus.addr[p]);
                exp_v[p] = bus.req[p] && bus.gnt[p];
                if (exp_v[p]) begin
                    if (bus.we[p]) begin
                        exp_d[p] = '0;
                        exp_k[p] = 1'b1;
                    end else begin
                        exp_d[p] = mem_m[a];
                        exp_k[p] = known_m[a];
                    end
                    $display("txn port%0d %s addr=0x%02h wdata=0x%08h be=0x%1h",
                             p, bus.we[p] ? "WR" : "RD", a, bus.wdata[p], bus.be[p]);
                end
            end
            for (int p = 0; p < NP; p++) begin
                a = int'(bus.addr[p]);
                if (bus.req[p] && bus.gnt[p] && bus.we[p]) begin
                    for (int i = 0; i < 4; i++)
                        if (bus.be[p][i]) mem_m[a][8*i +: 8] = bus.wdata[p][8*i +: 8];
                    known_m[a] = known_m[a] || (bus.be[p] == 4'hF);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge
    // ------------------------------------------------------------------
    task automatic drive(input int p, input bit r, input bit w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        bus.req[p]   = r;
        bus.we[p]    = w;
        bus.addr[p]  = a;
        bus.wdata[p] = d;
        bus.be[p]    = be;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    logic [1:0] exp_g [4];

    initial begin
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        idle_all();
        rst = 1'b1;
        // Request held during reset must not be granted.
        drive(0, 1'b1, 1'b1, 8'h10, 32'h12345678, 4'hF);
        to_neg();
        chk("reset_gnt", 32'(bus.gnt), 32'd0);
        chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
        to_pos();
        to_pos();
        idle_all();
        rst = 1'b0;
        to_pos();

        // T1: write then read addr 5
        drive(0, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF);
        to_neg();
        chk("t1_wr_gnt", 32'(bus.gnt), 32'h1);
        to_pos();
        drive(0, 1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
        to_neg();
        chk("t1_rd_gnt", 32'(bus.gnt), 32'h1);
        chk("t1_wr_rvalid", 32'(bus.rvalid), 32'h1);
        chk("t1_wr_rdata", bus.rdata[0], 32'h0);
        to_pos();
        idle_all();
        to_neg();
        chk("t1_rd_rvalid", 32'(bus.rvalid), 32'h1);
        chk("t1_rd_rdata", bus.rdata[0], 32'hDEADBEEF);
        to_pos();

        // T2: byte enables on addr 8
        drive(0, 1'b1, 1'b1, 8'h08, 32'h11223344, 4'hF);
        to_pos();
        drive(0, 1'b1, 1'b1, 8'h08, 32'hAABBCCDD, 4'h5);
        to_pos();
        drive(0, 1'b1, 1'b0, 8'h08, 32'h0, 4'h0);
        to_pos();
        idle_all();
        to_neg();
        chk("t2_be_rdata", bus.rdata[0], 32'h11BB33DD);
        to_pos();

        // T3: parallel access to banks 0 and 1
        drive(0, 1'b1, 1'b1, 8'h00, 32'hA0A00000, 4'hF);
        drive(1, 1'b1, 1'b1, 8'h01, 32'hB1B10001, 4'hF);
        to_neg();
        chk("t3_wr_gnt", 32'(bus.gnt), 32'h3);
        to_pos();
        drive(0, 1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
        to_neg();
        chk("t3_rd_gnt", 32'(bus.gnt), 32'h3);
        to_pos();
        idle_all();
        to_neg();
        chk("t3_rvalid", 32'(bus.rvalid), 32'h3);
        chk("t3_rdata_p0", bus.rdata[0], 32'hA0A00000);
        chk("t3_rdata_p1", bus.rdata[1], 32'hB1B10001);
        to_pos();

        // T4: both ports contend for bank 2; setup via port1 leaves rr at port0
        drive(1, 1'b1, 1'b1, 8'h02, 32'h22222222, 4'hF);
        to_pos();
        drive(1, 1'b1, 1'b1, 8'h06, 32'h66666666, 4'hF);
        to_pos();
        idle_all();
        to_pos();
`ifdef CONV1D_SRAM_CONFLICT_CNT_EN
        cnt_before = conflict_cnt;
`endif
        drive(0, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 8'h06, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            to_neg();
            chk($sformatf("t4_gnt_c%0d", i), 32'(bus.gnt), 32'(exp_g[i]));
            if (i > 0) chk($sformatf("t4_rvalid_c%0d", i), 32'(bus.rvalid), 32'(exp_g[i-1]));
            if (i == 1) chk("t4_rdata_p0", bus.rdata[0], 32'h22222222);
            to_pos();
        end
        idle_all();
        to_neg();
        chk("t4_rvalid_last", 32'(bus.rvalid), 32'h2);
        chk("t4_rdata_p1", bus.rdata[1], 32'h66666666);
`ifdef CONV1D_SRAM_CONFLICT_CNT_EN
        chk("t4_conflict_cnt", conflict_cnt - cnt_before, 32'd4);
`endif
        to_pos();

        // T5: reset the cycle after a grant (bank 3 rr moves to port1 first)
        drive(0, 1'b1, 1'b0, 8'h03, 32'h0, 4'h0);
        to_neg();
        chk("t5_gnt", 32'(bus.gnt), 32'h1);
        to_pos();
        idle_all();
        rst = 1'b1;
        to_neg();
        chk("t5_rvalid_in_rst", 32'(bus.rvalid), 32'h0);
        chk("t5_rdata_in_rst", bus.rdata[0], 32'h0);
        to_pos();
        rst = 1'b0;
        to_neg();
        chk("t5_rvalid_after", 32'(bus.rvalid), 32'h0);
        to_pos();
        drive(0, 1'b1, 1'b0, 8'h03, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 8'h07, 32'h0, 4'h0);
        to_neg();
        chk("t5_rr_restart", 32'(bus.gnt), 32'h1);
        to_pos();
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        to_neg();
        chk("t5_rr_second", 32'(bus.gnt), 32'h2);
        to_pos();
        idle_all();
        to_pos();

        // T6: back-to-back write/read of addr 0x3F on port1
        drive(1, 1'b1, 1'b1, 8'h3F, 32'h00000001, 4'hF);
        to_neg();
        chk("t6_wr_gnt", 32'(bus.gnt), 32'h2);
        to_pos();
        drive(1, 1'b1, 1'b0, 8'h3F, 32'h0, 4'h0);
        to_neg();
        chk("t6_rd_gnt", 32'(bus.gnt), 32'h2);
        to_pos();
        idle_all();
        to_neg();
        chk("t6_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t6_rdata", bus.rdata[1], 32'h00000001);
        to_pos();
        to_pos();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
